ar_burst_addr_gen: RTL and testbench

//  Read-burst address sequencer directly downstream of the read slave's AR handshake. Takes one accepted AR command
//  (addr/len/size/burst/id) and emits one beat address per data beat (FIXED/INCR/WRAP) to the device-side memory port.
//  The read slave uses beat_id/beat_last to build RID/RLAST. Single clock domain, one burst in flight.

---
 rtl/ar_burst_addr_gen.sv | 203 ++++++++++++++++++++
 tb/tb_ar_burst_addr_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ar_burst_addr_gen.sv
// Read-burst address sequencer: accepts one AR command and emits one beat
// address per data beat (FIXED / INCR / WRAP), with ID, index, last and
// error flags for the read slave to build RID/RLAST/RRESP.
module ar_burst_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_len,
    input  logic [1:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    input  logic [ID_W-1:0]   cmd_id,
    output logic              beat_valid,
    input  logic              beat_ready,
    output logic [ADDR_W-1:0] beat_addr,
    output logic [ID_W-1:0]   beat_id,
    output logic [3:0]        beat_idx,
    output logic              beat_last,
    output logic              beat_err
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    // Control state
    state_t            r_state;
    state_t            w_state_next;

    // Per-burst captured context
    logic [3:0]        r_len;
    logic [1:0]        r_mode;      // effective sequencing mode: FIXED/INCR/WRAP
    logic [ADDR_W-1:0] r_bmask;     // bytes-per-beat minus one
    logic [ADDR_W-1:0] r_wmask;     // wrap span minus one (WRAP mode only)

    // Registered beat outputs
    logic [ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]   r_id;
    logic [3:0]        r_idx;
    logic              r_last;
    logic              r_err;

    // Command decode
    logic              w_accept;
    logic              w_beat_fire;
    logic [1:0]        w_size_eff;
    logic [ADDR_W-1:0] w_cmd_bmask;
    logic [4:0]        w_beats;
    logic [6:0]        w_span;
    logic [ADDR_W-1:0] w_cmd_wmask;
    logic              w_wrap_len_ok;
    logic              w_wrap_legal;
    logic              w_unaligned;
    logic              w_cmd_err;
    logic [1:0]        w_cmd_mode;
    logic [ADDR_W-1:0] w_cmd_addr0;

    // Next-beat address generation
    logic [ADDR_W-1:0] w_step_addr;
    logic [ADDR_W-1:0] w_incr_addr;
    logic [ADDR_W-1:0] w_wrap_addr;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_cross_4k;

    assign w_accept    = (r_state == S_IDLE)  && cmd_valid;
    assign w_beat_fire = (r_state == S_BURST) && beat_ready;

    // An 8-byte beat does not fit a 32-bit bus; sequence it as 4 bytes.
    assign w_size_eff  = (cmd_size == 2'd3) ? 2'd2 : cmd_size;

    // Byte-offset mask for the effective beat size
    always_comb begin
        w_cmd_bmask = '0;
        case (w_size_eff)
            2'd0:    w_cmd_bmask = '0;
            2'd1:    w_cmd_bmask = ADDR_W'(1);
            default: w_cmd_bmask = ADDR_W'(3);
        endcase
    end

    assign w_beats       = {1'b0, cmd_len} + 5'd1;
    assign w_span        = {2'b00, w_beats} << w_size_eff;
    assign w_cmd_wmask   = {{(ADDR_W-7){1'b0}}, w_span - 7'd1};
    assign w_wrap_len_ok = (cmd_len == 4'd1) || (cmd_len == 4'd3) ||
                           (cmd_len == 4'd7) || (cmd_len == 4'd15);
    assign w_wrap_legal  = (cmd_burst == BURST_WRAP) && w_wrap_len_ok;
    assign w_unaligned   = |(cmd_addr & w_cmd_bmask);

    // Error sources known at capture time; 4KB crossings are added later.
    assign w_cmd_err = (cmd_size == 2'd3) ||
                       (cmd_burst == BURST_RSVD) ||
                       ((cmd_burst == BURST_WRAP) && !w_wrap_len_ok) ||
                       (w_wrap_legal && w_unaligned);

    // Illegal WRAP lengths and the reserved encoding fall back to INCR.
    always_comb begin
        w_cmd_mode = BURST_INCR;
        if (cmd_burst == BURST_FIXED) begin
            w_cmd_mode = BURST_FIXED;
        end else if (w_wrap_legal) begin
            w_cmd_mode = BURST_WRAP;
        end
    end

    // Only a legal WRAP aligns beat 0; FIXED/INCR start at the raw address.
    assign w_cmd_addr0 = w_wrap_legal ? (cmd_addr & ~w_cmd_bmask) : cmd_addr;

    assign w_step_addr = r_addr + r_bmask + ADDR_W'(1);
    assign w_incr_addr = (r_addr & ~r_bmask) + r_bmask + ADDR_W'(1);
    assign w_wrap_addr = (r_addr & ~r_wmask) | (w_step_addr & r_wmask);

    // Select the address of the following beat for the active mode
    always_comb begin
        w_next_addr = r_addr;
        case (r_mode)
            BURST_FIXED: w_next_addr = r_addr;
            BURST_WRAP:  w_next_addr = w_wrap_addr;
            default:     w_next_addr = w_incr_addr;
        endcase
    end

    assign w_cross_4k = (w_next_addr[ADDR_W-1:12] != r_addr[ADDR_W-1:12]);

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one burst in flight, back to idle after the last beat
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid)             w_state_next = S_BURST;
            S_BURST: if (beat_ready && r_last)  w_state_next = S_IDLE;
            default:                            w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state register
    always_comb begin
        cmd_ready  = (r_state == S_IDLE);
        beat_valid = (r_state == S_BURST);
    end

    // Capture command, advance beat on handshake, clear on burst completion
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_len   <= '0;
            r_mode  <= BURST_FIXED;
            r_bmask <= '0;
            r_wmask <= '0;
            r_addr  <= '0;
            r_id    <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_len   <= cmd_len;
            r_mode  <= w_cmd_mode;
            r_bmask <= w_cmd_bmask;
            r_wmask <= w_cmd_wmask;
            r_addr  <= w_cmd_addr0;
            r_id    <= cmd_id;
            r_idx   <= 4'd0;
            r_last  <= (cmd_len == 4'd0);
            r_err   <= w_cmd_err;
        end else if (w_beat_fire) begin
            if (r_last) begin
                r_addr <= '0;
                r_id   <= '0;
                r_idx  <= 4'd0;
                r_last <= 1'b0;
                r_err  <= 1'b0;
            end else begin
                r_addr <= w_next_addr;
                r_idx  <= r_idx + 4'd1;
                r_last <= ((r_idx + 4'd1) == r_len);
                r_err  <= r_err | w_cross_4k;
            end
        end
    end

    assign beat_addr = r_addr;
    assign beat_id   = r_id;
    assign beat_idx  = r_idx;
    assign beat_last = r_last;
    assign beat_err  = r_err;

endmodule

// File: tb/tb_ar_burst_addr_gen.sv
// Randomized bench for ar_burst_addr_gen: a per-beat arithmetic reference
// model predicts every beat address and error flag; random beat_ready stalls
// and junk command inputs during bursts exercise hold and ignore behaviour.
module tb_ar_burst_addr_gen;

    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [3:0]        cmd_len;
    logic [1:0]        cmd_size;
    logic [1:0]        cmd_burst;
    logic [ID_W-1:0]   cmd_id;
    logic              beat_valid;
    logic              beat_ready;
    logic [ADDR_W-1:0] beat_addr;
    logic [ID_W-1:0]   beat_id;
    logic [3:0]        beat_idx;
    logic              beat_last;
    logic              beat_err;

    int n_tests = 0;
    int n_fail  = 0;

    ar_burst_addr_gen #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .cmd_id     (cmd_id),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_addr  (beat_addr),
        .beat_id    (beat_id),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .beat_err   (beat_err)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    function automatic bit wrap_len_legal(input logic [3:0] len);
        return (len == 1) || (len == 3) || (len == 7) || (len == 15);
    endfunction

    // Error known from the command alone
    function automatic bit model_cmd_err(input logic [31:0] a, input logic [3:0] len,
                                         input logic [1:0] size, input logic [1:0] burst);
        longint b;
        b = longint'(1) << ((size == 2'd3) ? 2 : size);
        if (size == 2'd3) return 1'b1;
        if (burst == 2'b11) return 1'b1;
        if (burst == 2'b10 && !wrap_len_legal(len)) return 1'b1;
        if (burst == 2'b10 && (longint'(a) % b) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Address of beat i computed directly from the burst rules
    function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [3:0] len,
                                               input logic [1:0] size, input logic [1:0] burst,
                                               input int i);
        longint b, w, base, start, off, la;
        la = longint'(a);
        b  = longint'(1) << ((size == 2'd3) ? 2 : size);
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && wrap_len_legal(len)) begin
            w     = (longint'(len) + 1) * b;
            base  = (la / w) * w;
            start = (la / b) * b;
            off   = (start - base + longint'(i) * b) % w;
            return 32'(base + off);
        end
        if (i == 0) return a;
        return 32'((la / b) * b + longint'(i) * b);
    endfunction

    task automatic run_burst(input logic [31:0] a, input logic [3:0] len, input logic [1:0] size,
                             input logic [1:0] burst, input logic [3:0] id);
        logic [31:0] exp_a;
        logic [31:0] nxt_a;
        bit          exp_e;
        bit          rdy;
        int          i;
        int          cyc;
        int          stalls;
        check_eq("idle_cmd_ready", cmd_ready, 1);
        check_eq("idle_beat_valid", beat_valid, 0);
        cmd_valid  = 1'b1;
        cmd_addr   = a;
        cmd_len    = len;
        cmd_size   = size;
        cmd_burst  = burst;
        cmd_id     = id;
        beat_ready = 1'($urandom_range(0, 1));
        step();
        // Junk command inputs during the burst must be ignored
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_len   = 4'($urandom);
        cmd_size  = 2'($urandom);
        cmd_burst = 2'($urandom);
        cmd_id    = 4'($urandom);
        exp_e  = model_cmd_err(a, len, size, burst);
        exp_a  = model_addr(a, len, size, burst, 0);
        i      = 0;
        cyc    = 0;
        stalls = 0;
        while (i <= int'(len)) begin
            if (cyc > 200) begin
                check_eq("burst_timeout", 1, 0);
                break;
            end
            check_eq("beat_valid", beat_valid, 1);
            check_eq("cmd_ready_busy", cmd_ready, 0);
            check_eq("beat_addr", beat_addr, exp_a);
            check_eq("beat_id", beat_id, id);
            check_eq("beat_idx", beat_idx, i);
            check_eq("beat_last", beat_last, (i == int'(len)));
            check_eq("beat_err", beat_err, exp_e);
            rdy        = ($urandom_range(0, 2) != 0);
            beat_ready = rdy;
            if (rdy && i == int'(len)) cmd_valid = 1'b0;
            else                       cmd_valid = 1'($urandom_range(0, 1));
            step();
            cyc++;
            if (rdy) begin
                i++;
                if (i <= int'(len)) begin
                    nxt_a = model_addr(a, len, size, burst, i);
                    if (nxt_a[31:12] != exp_a[31:12]) exp_e = 1'b1;
                    exp_a = nxt_a;
                end
            end else begin
                stalls++;
            end
        end
        cmd_valid = 1'b0;
        check_eq("post_beat_valid", beat_valid, 0);
        check_eq("post_cmd_ready", cmd_ready, 1);
        check_eq("post_beat_err", beat_err, 0);
        $display("[TB] burst addr=0x%08h len=%0d size=%0d burst=%0d id=%0d beats=%0d stalls=%0d",
                 a, len, size, burst, id, i, stalls);
        beat_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic check_all_zero(input string phase);
        check_eq({phase, "_cmd_ready"}, cmd_ready, 1);
        check_eq({phase, "_beat_valid"}, beat_valid, 0);
        check_eq({phase, "_beat_addr"}, beat_addr, 0);
        check_eq({phase, "_beat_id"}, beat_id, 0);
        check_eq({phase, "_beat_idx"}, beat_idx, 0);
        check_eq({phase, "_beat_last"}, beat_last, 0);
        check_eq({phase, "_beat_err"}, beat_err, 0);
    endtask

    task automatic reset_mid_burst();
        int cyc;
        cmd_valid  = 1'b1;
        cmd_addr   = 32'h0000_0100;
        cmd_len    = 4'd7;
        cmd_size   = 2'd2;
        cmd_burst  = 2'b01;
        cmd_id     = 4'd9;
        beat_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        cyc = 0;
        while (!(beat_valid && beat_idx == 4'd2) && cyc < 20) begin
            step();
            cyc++;
        end
        check_eq("rst_reached_beat2", (beat_valid && beat_idx == 4'd2), 1);
        check_eq("rst_beat2_addr", beat_addr, 32'h0000_0108);
        ARESET = 1'b1;
        step();
        check_all_zero("midrst");
        ARESET     = 1'b0;
        beat_ready = 1'b0;
        step();
        check_all_zero("midrst_idle");
        $display("[TB] reset during beat 2 of len=7 burst");
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        ARESET     = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_size   = '0;
        cmd_burst  = '0;
        cmd_id     = '0;
        beat_ready = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        ARESET = 1'b0;
        step();

        run_burst(32'h0000_0100, 4'd3, 2'd2, 2'b01, 4'd1);
        run_burst(32'h0000_0038, 4'd3, 2'd2, 2'b10, 4'd2);
        run_burst(32'h0000_0200, 4'd2, 2'd1, 2'b00, 4'd3);
        run_burst(32'h0000_0FFC, 4'd1, 2'd2, 2'b01, 4'd4);
        run_burst(32'h0000_0FFC, 4'd2, 2'd2, 2'b10, 4'd5);
        run_burst(32'h0000_0101, 4'd2, 2'd1, 2'b01, 4'd6);
        run_burst(32'h0000_0101, 4'd2, 2'd3, 2'b01, 4'd7);
        run_burst(32'h0000_003A, 4'd3, 2'd2, 2'b10, 4'd8);
        run_burst(32'h0000_0040, 4'd0, 2'd0, 2'b11, 4'd10);
        run_burst(32'hFFFF_FFF8, 4'd3, 2'd2, 2'b01, 4'd11);

        reset_mid_burst();
        run_burst(32'h0000_1000, 4'd15, 2'd2, 2'b10, 4'd12);

        for (int n = 0; n < 200; n++) begin
            a   = $urandom;
            sel = $urandom_range(0, 3);
            if (sel == 0) a = (a & 32'hFFFF_F000) - 32'($urandom_range(0, 64));
            if (sel == 1) a = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
            run_burst(a, 4'($urandom), 2'($urandom), 2'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
